// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module   : uart_tx_mmio
// Function : picorv32 memory-bus slave feeding a small TX FIFO and 8N1 serialiser
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h8008,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  output logic        txd,
  output logic        irq_empty
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam int c_baud_w = $clog2(CLK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t               r_state, w_state_nx;
  logic [c_baud_w-1:0]  r_baud, w_baud_nx;
  logic [2:0]           r_bit, w_bit_nx;
  logic [7:0]           r_shift, w_shift_nx;
  logic                 w_pop;

  logic [7:0]           r_fifo [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_overflow;
  logic                 r_req_push, r_req_clr;
  logic [7:0]           r_req_byte;

  logic w_sel_data, w_sel_stat, w_take, w_is_read;
  logic w_empty, w_full, w_busy, w_push_ok, w_tick;
  logic [3:0]  w_count4;
  logic [31:0] w_status;
  logic        unused_wdata;

  assign w_sel_data   = (mem_addr == BASE_ADDR);
  assign w_sel_stat   = (mem_addr == BASE_ADDR + 32'd4);
  assign w_is_read    = (mem_wstrb == 4'b0000);
  assign w_take       = mem_valid & ~mem_ready_o & (w_sel_data | w_sel_stat);
  assign unused_wdata = ^mem_wdata[31:8];

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign w_busy    = (r_state != S_IDLE);
  assign w_count4  = 4'(r_count);
  assign w_status  = {24'b0, w_count4, r_overflow, w_busy, w_empty, w_full};
  // A full FIFO still accepts a byte when the serialiser pops in the same cycle.
  assign w_push_ok = r_req_push & (~w_full | w_pop);
  assign w_tick    = (r_baud == c_baud_w'(CLK_DIV - 1));

  // Requests are captured when taken and acted upon in the acknowledge cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      r_req_push  <= 1'b0;
      r_req_clr   <= 1'b0;
      r_req_byte  <= '0;
    end else begin
      mem_ready_o <= w_take;
      mem_rdata_o <= (w_take && w_sel_stat && w_is_read) ? w_status : '0;
      r_req_push  <= w_take & w_sel_data & mem_wstrb[0];
      r_req_clr   <= w_take & w_sel_stat & w_is_read;
      r_req_byte  <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= r_req_byte;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (r_req_push && w_full && !w_pop) r_overflow <= 1'b1;
      else if (r_req_clr)                 r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      irq_empty <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_baud    <= w_baud_nx;
      r_bit     <= w_bit_nx;
      r_shift   <= w_shift_nx;
      irq_empty <= w_empty & ~w_busy;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = w_tick ? '0 : r_baud + c_baud_w'(1);
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nx = '0;
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_shift_nx = r_fifo[r_rd_ptr];
          w_state_nx = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nx = S_DATA;
          w_bit_nx   = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nx = r_shift >> 1;
          w_bit_nx   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        // Back-to-back frames: reload straight into START with no idle gap.
        if (w_tick) begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_shift_nx = r_fifo[r_rd_ptr];
            w_state_nx = S_START;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (r_state)
      S_START: txd = 1'b0;
      S_DATA:  txd = r_shift[0];
      default: txd = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ============================================================================
// Module   : tb_uart_tx_mmio
// Function : scoreboard bench for uart_tx_mmio with a txd frame decoder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_mmio;

  localparam int          CLK_DIV = 4;
  localparam logic [31:0] BASE    = 32'h8008;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        txd;
  logic        irq_empty;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready_o(mem_ready_o),
    .mem_rdata_o(mem_rdata_o), .txd(txd), .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard of bytes expected on txd, in order
  logic [7:0] exp_q[$];
  int         frame_start[$];
  int         frames_done = 0;
  bit         mon_active = 1'b0;

  // Frame decoder: t=0 is the first low cycle, bit centres every CLK_DIV cycles.
  initial begin : monitor
    int         t;
    int         start_c;
    logic [7:0] sh;
    logic [7:0] e;
    t = 0; start_c = 0; sh = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (txd == 1'b0) begin
          mon_active = 1'b1;
          t = 0;
          start_c = cyc;
        end
      end else begin
        t++;
        if (t == 2) begin
          check("start_bit", 32'(txd), 32'd0);
        end else if (t > 2 && t <= 34 && ((t - 2) % CLK_DIV) == 0) begin
          sh = {txd, sh[7:1]};
        end else if (t == 38) begin
          check("stop_bit", 32'(txd), 32'd1);
          check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(sh), 32'(e));
          end
          frame_start.push_back(start_c);
          frames_done++;
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     output logic [31:0] rdata, output bit acked, output int ack_cyc);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    acked = 1'b0; rdata = '0; ack_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_ready_o) begin
        acked = 1'b1; rdata = mem_rdata_o; ack_cyc = cyc;
        break;
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic wr(input logic [7:0] b, input bit queued, output int ack_cyc);
    logic [31:0] rd;
    bit          ack;
    if (queued) exp_q.push_back(b);
    bus(BASE, {24'hABCDEF, b}, 4'b0001, rd, ack, ack_cyc);
    check("wr_ack", 32'(ack), 32'd1);
  endtask

  task automatic rd_status(input string tag, input logic [31:0] exp);
    logic [31:0] rd;
    bit          ack;
    int          ac;
    bus(BASE + 32'd4, 32'h0, 4'b0000, rd, ack, ac);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check(tag, rd, exp);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (frames_done < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("frames_in_time", 32'(frames_done >= n), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          ac;
    int          ac2;
    int          f0;
    int          k;
    logic [31:0] rd;
    bit          ack;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(mem_ready_o), 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(irq_empty), 32'd1);
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(posedge clk);
    rd_status("status_idle", 32'h2);

    // Single byte: latency, one-cycle ack, busy status, irq re-assert
    wr(8'h55, 1'b1, ac);
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(mem_ready_o), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("irq_busy", 32'(irq_empty), 32'd0);
    rd_status("status_busy", 32'h6);
    wait_frames(1, 200);
    check("start_latency", 32'(frame_start[0] - ac), 32'd2);
    repeat (4) @(posedge clk); #1;
    check("irq_after", 32'(irq_empty), 32'd1);
    check("txd_idle", 32'(txd), 32'd1);
    rd_status("status_after", 32'h2);

    // Back-to-back frames are contiguous
    f0 = frames_done;
    wr(8'hA5, 1'b1, ac);
    wr(8'h3C, 1'b1, ac2);
    wait_frames(f0 + 2, 300);
    check("b2b_gap", 32'(frame_start[f0 + 1] - frame_start[f0]), 32'd40);

    // Overflow: first byte goes straight to the serialiser, four fill the FIFO, sixth dropped
    f0 = frames_done;
    for (int i = 0; i < 6; i++) wr(8'(8'h10 + i), (i < 5), ac);
    rd_status("status_ovf", 32'h4D);
    rd_status("status_ovf_clr", 32'h45);
    wait_frames(f0 + 5, 500);
    repeat (4) @(posedge clk);
    rd_status("status_drained", 32'h2);

    // Undecoded addresses and byte-lane-less DATA write
    f0 = frames_done;
    bus(32'h8000, 32'h77, 4'b0001, rd, ack, ac);
    check("undec_8000_ack", 32'(ack), 32'd0);
    bus(32'h8010, 32'h77, 4'b0001, rd, ack, ac);
    check("undec_8010_ack", 32'(ack), 32'd0);
    bus(32'h8000, 32'h0, 4'b0000, rd, ack, ac);
    check("undec_rd_ack", 32'(ack), 32'd0);
    bus(BASE, 32'h99, 4'b0010, rd, ack, ac);
    check("wstrb_ack", 32'(ack), 32'd1);
    repeat (20) @(posedge clk); #1;
    check("no_frame", 32'(frames_done), 32'(f0));
    check("no_frame_txd", 32'(txd), 32'd1);
    rd_status("status_untouched", 32'h2);

    // Reset mid-frame while a data bit of 0x00 is driving txd low
    f0 = frames_done;
    wr(8'h00, 1'b1, ac);
    wr(8'h11, 1'b1, ac);
    k = 0;
    while (!mon_active && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("frame_began", 32'(mon_active), 32'd1);
    repeat (10) @(posedge clk);
    #2;
    check("txd_in_data", 32'(txd), 32'd0);
    resetn = 1'b0;
    #1;
    check("txd_async_rst", 32'(txd), 32'd1);
    check("irq_async_rst", 32'(irq_empty), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (100) @(posedge clk); #1;
    check("no_frame_after_rst", 32'(frames_done), 32'(f0));
    check("txd_after_rst", 32'(txd), 32'd1);
    rd_status("status_after_rst", 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
